// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC valid-ready memory bus: router state
// encoding, slave address map and the default error read data.
package soc_bus_pkg;

  // Router FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAM  = 2'd1,
    ST_IO   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Address decode result
  typedef enum logic [1:0] {
    DEC_RAM      = 2'd0,
    DEC_IO       = 2'd1,
    DEC_UNMAPPED = 2'd2
  } dec_e;

  localparam logic [31:0] RAM_BASE          = 32'h0000_0000;
  localparam logic [31:0] IO_BASE           = 32'h8000_0000;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // IO owns the upper half of the map; RAM is a 2^ram_bits window at RAM_BASE.
  function automatic dec_e decode_addr(input logic [31:0] addr, input int unsigned ram_bits);
    dec_e dec;
    if ((addr & IO_BASE) == IO_BASE) begin
      dec = DEC_IO;
    end else if (((addr - RAM_BASE) >> ram_bits) == 32'd0) begin
      dec = DEC_RAM;
    end else begin
      dec = DEC_UNMAPPED;
    end
    return dec;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Slave-stall watchdog. load_i starts a new wait (the load cycle's successor is
// wait cycle 1); en_i advances one cycle per clock. expired_o is registered and
// is high during the TIMEOUT_CYCLES-th wait cycle.
// Ports: clk, rst_n (sync, active-low), load_i, en_i, expired_o.
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W1 = CNT_W + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // cnt_q holds the index of the current wait cycle, starting at 1
  always_comb begin
    cnt_d     = cnt_q;
    expired_d = expired_q;
    if (load_i) begin
      cnt_d     = CNT_W'(1);
      expired_d = (TIMEOUT_CYCLES == 32'd1);
    end else if (en_i) begin
      cnt_d     = cnt_q + CNT_W'(1);
      expired_d = (({1'b0, cnt_q} + CNT_W1'(1)) == CNT_W1'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/mem_bus_router.sv
// Single-master to two-slave router (RAM / IO) for the valid-ready memory bus.
// Registers each CPU request, steers it by address, returns a registered
// response; unmapped or stalled accesses get ERR_RDATA and set sticky bus_err.
// Ports: clk, rst_n (sync, active-low); CPU side m_valid/m_ready/m_addr/
// m_wdata/m_wstrb/m_rdata; RAM and IO request/response channels; bus_err.
module mem_bus_router
  import soc_bus_pkg::*;
#(
  parameter int unsigned RAM_ADDR_BITS  = 17,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_wstrb,
  output logic [31:0] m_rdata,
  output logic        ram_valid,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  input  logic        ram_ready,
  input  logic [31:0] ram_rdata,
  output logic        io_valid,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic [3:0]  io_wstrb,
  input  logic        io_ready,
  input  logic [31:0] io_rdata,
  output logic        bus_err
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        m_ready_q, m_ready_d;
  logic        ram_valid_q, ram_valid_d;
  logic        io_valid_q, io_valid_d;
  logic        bus_err_q, bus_err_d;
  logic        tmo_load_c, tmo_en_c, tmo_expired;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (tmo_load_c),
    .en_i     (tmo_en_c),
    .expired_o(tmo_expired)
  );

  // Next state; registered outputs are computed from the next state so they
  // line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    bus_err_d   = bus_err_q;
    m_ready_d   = 1'b0;
    ram_valid_d = 1'b0;
    io_valid_d  = 1'b0;
    tmo_load_c  = 1'b0;
    tmo_en_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m_valid && !m_ready_q) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          wstrb_d = m_wstrb;
          case (decode_addr(m_addr, RAM_ADDR_BITS))
            DEC_RAM: begin
              state_d     = ST_RAM;
              ram_valid_d = 1'b1;
              tmo_load_c  = 1'b1;
            end
            DEC_IO: begin
              state_d    = ST_IO;
              io_valid_d = 1'b1;
              tmo_load_c = 1'b1;
            end
            default: begin
              state_d   = ST_RESP;
              rdata_d   = ERR_RDATA;
              bus_err_d = 1'b1;
              m_ready_d = 1'b1;
            end
          endcase
        end
      end
      ST_RAM: begin
        tmo_en_c = 1'b1;
        // A ready in the expiry cycle still wins over the timeout
        if (ram_ready) begin
          state_d   = ST_RESP;
          rdata_d   = ram_rdata;
          m_ready_d = 1'b1;
        end else if (tmo_expired) begin
          state_d   = ST_RESP;
          rdata_d   = ERR_RDATA;
          bus_err_d = 1'b1;
          m_ready_d = 1'b1;
        end else begin
          ram_valid_d = 1'b1;
        end
      end
      ST_IO: begin
        tmo_en_c = 1'b1;
        if (io_ready) begin
          state_d   = ST_RESP;
          rdata_d   = io_rdata;
          m_ready_d = 1'b1;
        end else if (tmo_expired) begin
          state_d   = ST_RESP;
          rdata_d   = ERR_RDATA;
          bus_err_d = 1'b1;
          m_ready_d = 1'b1;
        end else begin
          io_valid_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      m_ready_q   <= 1'b0;
      ram_valid_q <= 1'b0;
      io_valid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      m_ready_q   <= m_ready_d;
      ram_valid_q <= ram_valid_d;
      io_valid_q  <= io_valid_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Both slaves see the latched request; only valid selects the target
  assign m_ready   = m_ready_q;
  assign m_rdata   = rdata_q;
  assign ram_valid = ram_valid_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_wstrb = wstrb_q;
  assign io_valid  = io_valid_q;
  assign io_addr   = addr_q;
  assign io_wdata  = wdata_q;
  assign io_wstrb  = wstrb_q;
  assign bus_err   = bus_err_q;

endmodule
